// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the RGB LED arbiter.
//   state_t  : arbiter FSM states (IDLE, SHOW, GAP)
//   rgb_t    : 3-bit colour, {R,G,B}, 1 = lit
//   RGB_*    : named colour constants
//   rgb_gate : returns the colour when 'on', dark otherwise
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_OFF     = 3'b000;
    localparam rgb_t RGB_RED     = 3'b100;
    localparam rgb_t RGB_GREEN   = 3'b010;
    localparam rgb_t RGB_BLUE    = 3'b001;
    localparam rgb_t RGB_YELLOW  = 3'b110;
    localparam rgb_t RGB_CYAN    = 3'b011;
    localparam rgb_t RGB_MAGENTA = 3'b101;
    localparam rgb_t RGB_WHITE   = 3'b111;

    function automatic rgb_t rgb_gate(input rgb_t colour, input logic on);
        return on ? colour : RGB_OFF;
    endfunction

endpackage

// File: rtl/led_blink_gen.sv
// ---------------------------------------------------------------------------
// led_blink_gen
// Blink phase generator. The phase toggles every BLINK_HALF enabled cycles,
// counted from the last clear. A clear restarts the count with the phase ON.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   clear      in   synchronous restart (grant entry); wins over enable
//   enable     in   count this cycle (owner being displayed)
//   phase_next out  phase value that will be held after the coming edge,
//                   so the parent can register its LED outputs in step
// ---------------------------------------------------------------------------
module led_blink_gen #(
    parameter int BLINK_HALF = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic phase_next
);

    localparam int              CW   = $clog2(BLINK_HALF + 1);
    localparam logic [CW-1:0]   LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] count_q, count_d;
    logic          phase_q;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        count_d    = count_q;
        phase_next = phase_q;
        if (clear) begin
            count_d    = '0;
            phase_next = 1'b1;
        end else if (enable) begin
            if (count_q == LAST) begin
                count_d    = '0;
                phase_next = ~phase_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_next;
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// ---------------------------------------------------------------------------
// rgb_led_arbiter
// Shares one RGB LED among N_REQ requesters. Fixed priority (index 0 highest),
// minimum display hold before preemption, a dark gap between owners, and an
// optional blink of the granted colour. All outputs come straight from flops.
// Ports:
//   CLK        in   system clock
//   RST        in   asynchronous, active-high reset
//   REQ        in   level-sensitive request per requester
//   REQ_COLOR  in   {R,G,B} per requester, REQ_COLOR[3i+2:3i]
//   REQ_BLINK  in   1 = blink the granted colour
//   GRANT      out  one-hot current owner, 0 when no owner
//   BUSY       out  1 while in SHOW or GAP
//   LED_R/G/B  out  LED drives, 1 = lit
// ---------------------------------------------------------------------------
module rgb_led_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int BLINK_HALF = 500_000,
    parameter int MIN_HOLD   = 6_000_000,
    parameter int GAP_CYCLES = 1_200_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     REQ,
    input  logic [3*N_REQ-1:0]   REQ_COLOR,
    input  logic [N_REQ-1:0]     REQ_BLINK,
    output logic [N_REQ-1:0]     GRANT,
    output logic                 BUSY,
    output logic                 LED_R,
    output logic                 LED_G,
    output logic                 LED_B
);

    localparam int            IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int            HW       = $clog2(MIN_HOLD + 1);
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    owner_q, owner_d, win_idx;
    rgb_t             colour_q, colour_d, win_colour;
    logic             blink_q, blink_d, win_blink;
    logic [HW-1:0]    hold_q, hold_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             any_req, higher_req, owner_req;
    logic             grant_entry, phase_next;
    logic [N_REQ-1:0] grant_d;
    rgb_t             led_d, led_q;
    logic             busy_d;

    // Priority encoder: scan from the lowest priority up so the lowest set
    // index is the last one written and therefore wins.
    always_comb begin
        win_idx    = '0;
        win_colour = RGB_OFF;
        win_blink  = 1'b0;
        any_req    = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                win_idx    = IW'(i);
                win_colour = REQ_COLOR[3*i +: 3];
                win_blink  = REQ_BLINK[i];
                any_req    = 1'b1;
            end
        end
    end

    // Owner's own request and any request of strictly higher priority.
    always_comb begin
        owner_req  = 1'b0;
        higher_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == owner_q) owner_req = REQ[i];
            if (IW'(i) < owner_q)  higher_req = higher_req | REQ[i];
        end
    end

    // Next-state logic. The gap counter is cleared when GAP is left, so it is
    // already zero on every GAP entry.
    always_comb begin
        state_d     = state_q;
        grant_entry = 1'b0;
        hold_d      = hold_q;
        gap_d       = gap_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = SHOW;
                    grant_entry = 1'b1;
                end
            end
            SHOW: begin
                // A dropped owner request leaves at once; preemption waits
                // for the hold to saturate. Both at once is still one exit.
                if (!owner_req || (hold_q == HOLD_MAX && higher_req)) begin
                    state_d = GAP;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (any_req) begin
                        state_d     = SHOW;
                        grant_entry = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_entry) hold_d = '0;
    end

    // Colour and blink mode are captured only at grant entry.
    assign owner_d  = grant_entry ? win_idx    : owner_q;
    assign colour_d = grant_entry ? win_colour : colour_q;
    assign blink_d  = grant_entry ? win_blink  : blink_q;

    led_blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk        (CLK),
        .rst        (RST),
        .clear      (grant_entry),
        .enable     (state_q == SHOW),
        .phase_next (phase_next)
    );

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        grant_d = '0;
        led_d   = RGB_OFF;
        if (state_d == SHOW) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_d[i] = (owner_d == IW'(i));
            end
            led_d = rgb_gate(colour_d, !blink_d || phase_next);
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            colour_q <= RGB_OFF;
            blink_q  <= 1'b0;
            hold_q   <= '0;
            gap_q    <= '0;
            GRANT    <= '0;
            BUSY     <= 1'b0;
            led_q    <= RGB_OFF;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            colour_q <= colour_d;
            blink_q  <= blink_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            GRANT    <= grant_d;
            BUSY     <= busy_d;
            led_q    <= led_d;
        end
    end

    assign {LED_R, LED_G, LED_B} = led_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rgb_led_arbiter
// Self-checking bench for rgb_led_arbiter with N_REQ=4, BLINK_HALF=4,
// MIN_HOLD=10, GAP_CYCLES=2. Inputs change 1 ns after a rising edge; the
// expected outputs for the next cycle are queued with the stimulus and
// compared 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_rgb_led_arbiter;
    import led_pkg::*;

    localparam int N_REQ      = 4;
    localparam int BLINK_HALF = 4;
    localparam int MIN_HOLD   = 10;
    localparam int GAP_CYCLES = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [N_REQ-1:0]     REQ;
    logic [3*N_REQ-1:0]   REQ_COLOR;
    logic [N_REQ-1:0]     REQ_BLINK;
    logic [N_REQ-1:0]     GRANT;
    logic                 BUSY;
    logic                 LED_R, LED_G, LED_B;

    rgb_led_arbiter #(
        .N_REQ      (N_REQ),
        .BLINK_HALF (BLINK_HALF),
        .MIN_HOLD   (MIN_HOLD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_COLOR (REQ_COLOR),
        .REQ_BLINK (REQ_BLINK),
        .GRANT     (GRANT),
        .BUSY      (BUSY),
        .LED_R     (LED_R),
        .LED_G     (LED_G),
        .LED_B     (LED_B)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
        rgb_t       led;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] col;
        logic [3:0]  blk;
        logic [3:0]  grant;
        logic        busy;
        rgb_t        led;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs(input exp_t e);
        check({e.name, ".grant"}, 32'(GRANT), 32'(e.grant));
        check({e.name, ".busy"},  32'(BUSY),  32'(e.busy));
        check({e.name, ".led"},   32'({LED_R, LED_G, LED_B}), 32'(e.led));
    endtask

    task automatic expect_now(input logic [3:0] g, input logic b, input rgb_t l, input string name);
        exp_t e;
        e.grant = g; e.busy = b; e.led = l; e.name = name;
        compare_outputs(e);
    endtask

    // Drive one cycle of stimulus, queue what the DUT must show next cycle,
    // then pop and compare once the edge has been taken.
    task automatic step(input logic [3:0] req, input logic [11:0] col, input logic [3:0] blk,
                        input logic [3:0] g, input logic b, input rgb_t l, input string name);
        exp_t e;
        REQ       = req;
        REQ_COLOR = col;
        REQ_BLINK = blk;
        e.grant = g; e.busy = b; e.led = l; e.name = name;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        compare_outputs(e);
    endtask

    // From SHOW: drop every request, expect two dark gap cycles then IDLE.
    task automatic drain(input string name);
        step(4'b0000, 12'h000, 4'b0000, 4'b0000, 1'b1, RGB_OFF, {name, "_gap0"});
        step(4'b0000, 12'h000, 4'b0000, 4'b0000, 1'b1, RGB_OFF, {name, "_gap1"});
        step(4'b0000, 12'h000, 4'b0000, 4'b0000, 1'b0, RGB_OFF, {name, "_idle"});
    endtask

    initial begin
        vec_t vecs[19];

        // Steady display, colour/blink latch, dark colour, gap behaviour.
        vecs[0]  = '{4'b0100, {RGB_OFF, RGB_MAGENTA, RGB_OFF, RGB_OFF},   4'b0000, 4'b0100, 1'b1, RGB_MAGENTA};
        vecs[1]  = '{4'b0100, {RGB_OFF, RGB_MAGENTA, RGB_OFF, RGB_OFF},   4'b0000, 4'b0100, 1'b1, RGB_MAGENTA};
        vecs[2]  = '{4'b0100, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0100, 4'b0100, 1'b1, RGB_MAGENTA};
        vecs[3]  = '{4'b0100, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0100, 4'b0100, 1'b1, RGB_MAGENTA};
        vecs[4]  = '{4'b0000, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[5]  = '{4'b0000, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[6]  = '{4'b0000, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b0, RGB_OFF};
        vecs[7]  = '{4'b0100, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0100, 1'b1, RGB_CYAN};
        vecs[8]  = '{4'b0000, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[9]  = '{4'b0100, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[10] = '{4'b0000, {RGB_OFF, RGB_CYAN,    RGB_OFF, RGB_OFF},   4'b0000, 4'b0000, 1'b0, RGB_OFF};
        vecs[11] = '{4'b1000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b1000, 1'b1, RGB_OFF};
        vecs[12] = '{4'b1000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b1000, 1'b1, RGB_OFF};
        vecs[13] = '{4'b0000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[14] = '{4'b0001, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[15] = '{4'b0001, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0001, 1'b1, RGB_WHITE};
        vecs[16] = '{4'b0000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[17] = '{4'b0000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0000, 1'b1, RGB_OFF};
        vecs[18] = '{4'b0000, {RGB_OFF, RGB_OFF,     RGB_OFF, RGB_WHITE}, 4'b0000, 4'b0000, 1'b0, RGB_OFF};

        RST       = 1'b1;
        REQ       = '0;
        REQ_COLOR = '0;
        REQ_BLINK = '0;
        #1;
        expect_now(4'b0000, 1'b0, RGB_OFF, "por");
        repeat (2) @(posedge CLK);
        #1;
        expect_now(4'b0000, 1'b0, RGB_OFF, "por_held");
        RST = 1'b0;

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].req, vecs[i].col, vecs[i].blk,
                 vecs[i].grant, vecs[i].busy, vecs[i].led, $sformatf("tbl%0d", i));
        end

        // Asynchronous reset in the middle of SHOW, between clock edges.
        step(4'b0010, {RGB_OFF, RGB_OFF, RGB_GREEN, RGB_OFF}, 4'b0000, 4'b0010, 1'b1, RGB_GREEN, "rst_show0");
        step(4'b0010, {RGB_OFF, RGB_OFF, RGB_GREEN, RGB_OFF}, 4'b0000, 4'b0010, 1'b1, RGB_GREEN, "rst_show1");
        #3 RST = 1'b1;
        #1 expect_now(4'b0000, 1'b0, RGB_OFF, "rst_async");
        @(posedge CLK);
        #1;
        expect_now(4'b0000, 1'b0, RGB_OFF, "rst_held");
        RST = 1'b0;
        step(4'b0000, 12'h000, 4'b0000, 4'b0000, 1'b0, RGB_OFF, "rst_idle");
        step(4'b0010, {RGB_OFF, RGB_OFF, RGB_GREEN, RGB_OFF}, 4'b0000, 4'b0010, 1'b1, RGB_GREEN, "rst_regrant");
        drain("rst");

        // Blink: 4 cycles lit, 4 dark from grant entry; REQ_BLINK change ignored.
        for (int k = 1; k <= 20; k++) begin
            step(4'b0010, {RGB_OFF, RGB_OFF, RGB_GREEN, RGB_OFF},
                 (k < 10) ? 4'b0010 : 4'b0000,
                 4'b0010, 1'b1, (((k - 1) / 4) % 2 == 0) ? RGB_GREEN : RGB_OFF,
                 $sformatf("blink%0d", k));
        end
        drain("blink");

        // Preemption: REQ[0] rises while owner 3 has hold count 3; owner 3
        // stays through the cycle where hold reaches 10, then gap, then 0.
        for (int k = 1; k <= 14; k++) begin
            logic [3:0] r, g;
            rgb_t       l;
            r = (k >= 5) ? 4'b1001 : 4'b1000;
            if (k <= 11) begin
                g = 4'b1000; l = RGB_BLUE;
            end else if (k <= 13) begin
                g = 4'b0000; l = RGB_OFF;
            end else begin
                g = 4'b0001; l = RGB_RED;
            end
            step(r, {RGB_BLUE, RGB_OFF, RGB_OFF, RGB_RED}, 4'b0000, g, 1'b1, l,
                 $sformatf("preempt%0d", k));
        end
        drain("preempt");

        // Owner drop before the hold saturates: leaves immediately.
        for (int k = 1; k <= 7; k++) begin
            logic [3:0] r, g;
            rgb_t       l;
            r = (k <= 4) ? 4'b0101 : 4'b0100;
            if (k <= 4) begin
                g = 4'b0001; l = RGB_RED;
            end else if (k <= 6) begin
                g = 4'b0000; l = RGB_OFF;
            end else begin
                g = 4'b0100; l = RGB_YELLOW;
            end
            step(r, {RGB_OFF, RGB_YELLOW, RGB_OFF, RGB_RED}, 4'b0000, g, 1'b1, l,
                 $sformatf("drop%0d", k));
        end
        drain("drop");

        // Lower priority waiting never preempts; then owner drops.
        for (int k = 1; k <= 63; k++) begin
            logic [3:0] r, g;
            rgb_t       l;
            r = (k <= 60) ? 4'b0101 : 4'b0100;
            if (k <= 60) begin
                g = 4'b0001; l = RGB_RED;
            end else if (k <= 62) begin
                g = 4'b0000; l = RGB_OFF;
            end else begin
                g = 4'b0100; l = RGB_YELLOW;
            end
            step(r, {RGB_OFF, RGB_YELLOW, RGB_OFF, RGB_RED}, 4'b0000, g, 1'b1, l,
                 $sformatf("nolow%0d", k));
        end
        drain("nolow");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
